// File: rtl/detector_jogada_chaves.sv
`default_nettype none
// ============================================================================
// Module  : detector_jogada_chaves
// Purpose : Debounces raw player switches into a registered one-hot jogada
//           plus one-cycle tem_jogada / jogada_invalida strobes.
// Revision: 1.0 - initial release
// ============================================================================
module detector_jogada_chaves #(
  parameter int DEBOUNCE_CICLOS = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] chaves,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       jogada_invalida,
  output logic [2:0] db_estado
);

  localparam int             CW       = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0]  C_ULTIMO = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0]  C_UM     = CW'(1);

  localparam logic [2:0] OCIOSO         = 3'd0;
  localparam logic [2:0] ESTABILIZANDO  = 3'd1;
  localparam logic [2:0] REGISTRA       = 3'd2;
  localparam logic [2:0] INVALIDA       = 3'd3;
  localparam logic [2:0] AGUARDA_SOLTAR = 3'd4;

  logic [2:0]    estado;
  logic [3:0]    amostra;
  logic [CW-1:0] contador;
  logic          um_quente;

  assign um_quente = (amostra != 4'b0000) && ((amostra & (amostra - 4'd1)) == 4'b0000);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      jogada   <= 4'b0000;
      amostra  <= 4'b0000;
      contador <= '0;
    end else if (!habilita) begin
      estado   <= OCIOSO;
      contador <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (chaves != 4'b0000) begin
            estado   <= ESTABILIZANDO;
            amostra  <= chaves;
            contador <= C_UM;
          end
        end
        ESTABILIZANDO: begin
          if (chaves == 4'b0000) begin
            estado   <= OCIOSO;
            contador <= '0;
          end else if (chaves != amostra) begin
            // Pattern changed mid-settle: restart the debounce on the new one
            amostra  <= chaves;
            contador <= C_UM;
          end else if (contador == C_ULTIMO) begin
            contador <= '0;
            if (um_quente) begin
              estado <= REGISTRA;
              jogada <= amostra;
            end else begin
              estado <= INVALIDA;
            end
          end else begin
            contador <= contador + C_UM;
          end
        end
        REGISTRA, INVALIDA: begin
          estado   <= AGUARDA_SOLTAR;
          contador <= '0;
        end
        AGUARDA_SOLTAR: begin
          // Counts consecutive all-released samples; any press restarts it
          if (chaves != 4'b0000) begin
            contador <= '0;
          end else if (contador == C_ULTIMO) begin
            estado   <= OCIOSO;
            contador <= '0;
          end else begin
            contador <= contador + C_UM;
          end
        end
        default: begin
          estado   <= OCIOSO;
          contador <= '0;
        end
      endcase
    end
  end

  assign tem_jogada      = (estado == REGISTRA);
  assign jogada_invalida = (estado == INVALIDA);
  assign db_estado       = estado;

endmodule
`default_nettype wire
